// File: rtl/frame_scaler_pipe.sv
// Pipelined camera-frame scaler: maps video counters onto a SRC_W x SRC_H frame buffer
// at 1x / 2x / 8/3x zoom, issues the read address and returns the fetched pixel with sideband aligned.
module frame_scaler_pipe #(
   parameter int                 SRC_W        = 240,
   parameter int                 SRC_H        = 320,
   parameter int                 PIXEL_W      = 16,
   parameter int                 READ_LATENCY = 2,
   parameter logic [PIXEL_W-1:0] BORDER_COLOR = '0,
   parameter int                 ADDR_W       = $clog2(SRC_W*SRC_H)
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic [1:0]         scale_in,
   input  logic               new_frame_in,
   input  logic [10:0]        hcount_in,
   input  logic [9:0]         vcount_in,
   input  logic               hsync_in,
   input  logic               vsync_in,
   input  logic               blank_in,
   input  logic [PIXEL_W-1:0] frame_buff_in,
   output logic [ADDR_W-1:0]  addr_out,
   output logic [PIXEL_W-1:0] pixel_out,
   output logic               hsync_out,
   output logic               vsync_out,
   output logic               blank_out,
   output logic               in_region_out
);

   localparam int          L        = READ_LATENCY + 2;
   localparam logic [31:0] SRC_W_U  = 32'(SRC_W);
   localparam logic [31:0] SRC_H_U  = 32'(SRC_H);
   localparam int          S_HS     = 0;
   localparam int          S_VS     = 1;
   localparam int          S_BL     = 2;
   localparam int          S_IR     = 3;
   // Cleared stages read as blanked so nothing stale can leave the pipe after reset.
   localparam logic [3:0]  SIDE_RST = 4'b0100;

   logic [1:0]         mode_q, mode_d;
   logic [12:0]        h3, v3, sx, sy;
   logic               in_region;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [3:0]         side_d;
   logic [L:1][3:0]    side_q;
   logic [PIXEL_W-1:0] pixel_q, pixel_d;

   always_comb begin
      mode_d = mode_q;
      if (new_frame_in) begin
         mode_d = (scale_in == 2'd3) ? 2'd0 : scale_in;
      end
   end

   // 3h and 3v are formed at full 13-bit width before the divide-by-8.
   always_comb begin
      h3 = {2'b00, hcount_in} + {1'b0, hcount_in, 1'b0};
      v3 = {3'b000, vcount_in} + {2'b00, vcount_in, 1'b0};
      sx = {2'b00, hcount_in};
      sy = {3'b000, vcount_in};
      case (mode_d)
         2'd1: begin
            sx = {3'b000, hcount_in[10:1]};
            sy = {4'b0000, vcount_in[9:1]};
         end
         2'd2: begin
            sx = h3 >> 3;
            sy = v3 >> 3;
         end
         default: ;
      endcase
      in_region = (32'(sx) < SRC_W_U) && (32'(sy) < SRC_H_U);
      addr_d    = in_region ? ADDR_W'(32'(sy) * SRC_W_U + 32'(sx)) : '0;
      side_d    = {in_region, blank_in, vsync_in, hsync_in};
   end

   // Stage L-1 of the sideband lines up with the frame buffer data for the same sample.
   always_comb begin
      pixel_d = frame_buff_in;
      if (side_q[L-1][S_BL]) begin
         pixel_d = '0;
      end else if (!side_q[L-1][S_IR]) begin
         pixel_d = BORDER_COLOR;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         mode_q  <= 2'd0;
         addr_q  <= '0;
         side_q  <= {L{SIDE_RST}};
         pixel_q <= '0;
      end else begin
         mode_q  <= mode_d;
         addr_q  <= addr_d;
         side_q  <= {side_q[L-1:1], side_d};
         pixel_q <= pixel_d;
      end
   end

   assign addr_out      = addr_q;
   assign pixel_out     = pixel_q;
   assign hsync_out     = side_q[L][S_HS];
   assign vsync_out     = side_q[L][S_VS];
   assign blank_out     = side_q[L][S_BL];
   assign in_region_out = side_q[L][S_IR] & ~side_q[L][S_BL];

endmodule

// File: tb/tb_frame_scaler_pipe.sv
// Bench for frame_scaler_pipe: directed vectors with literal expectations plus a per-cycle
// arithmetic model of the scaler checked on every falling edge.
module tb_frame_scaler_pipe;

   localparam int RL     = 2;
   localparam int L      = RL + 2;
   localparam int ADDR_W = 17;
   localparam int MAXS   = 4096;

   logic              clk_in = 1'b0;
   logic              rst_in;
   logic [1:0]        scale_in;
   logic              new_frame_in;
   logic [10:0]       hcount_in;
   logic [9:0]        vcount_in;
   logic              hsync_in, vsync_in, blank_in;
   logic [15:0]       frame_buff_in;
   logic [ADDR_W-1:0] addr_out;
   logic [15:0]       pixel_out;
   logic              hsync_out, vsync_out, blank_out, in_region_out;

   int pass_cnt  = 0;
   int total_cnt = 0;

   frame_scaler_pipe #(
      .SRC_W(240), .SRC_H(320), .PIXEL_W(16), .READ_LATENCY(RL),
      .BORDER_COLOR(16'h0000), .ADDR_W(ADDR_W)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .scale_in(scale_in), .new_frame_in(new_frame_in),
      .hcount_in(hcount_in), .vcount_in(vcount_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .blank_in(blank_in), .frame_buff_in(frame_buff_in), .addr_out(addr_out),
      .pixel_out(pixel_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
      .blank_out(blank_out), .in_region_out(in_region_out)
   );

   always #5 clk_in = ~clk_in;

   // Frame buffer: READ_LATENCY-cycle read, contents = low 16 bits of the address.
   logic [ADDR_W-1:0] bram_q [0:RL-1];
   always @(posedge clk_in) begin
      bram_q[0] <= addr_out;
      for (int i = 1; i < RL; i++) bram_q[i] <= bram_q[i-1];
   end
   assign frame_buff_in = bram_q[RL-1][15:0];

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      total_cnt++;
      if (act === 32'(exp)) pass_cnt++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   // Reference model: per input sample, mode and expected address/region from plain arithmetic.
   int s = 0;
   int rec_addr [0:MAXS-1];
   bit rec_ir   [0:MAXS-1];
   bit rec_hs   [0:MAXS-1];
   bit rec_vs   [0:MAXS-1];
   bit rec_bl   [0:MAXS-1];
   bit rec_rst  [0:MAXS-1];

   initial begin
      int mode, h, v, sx, sy;
      mode = 0;
      forever begin
         @(posedge clk_in);
         if (s < MAXS - 1) s = s + 1;
         if (!rst_in) mode = 0;
         else if (new_frame_in) mode = (scale_in == 2'd3) ? 0 : int'(scale_in);
         h = int'(hcount_in);
         v = int'(vcount_in);
         if (mode == 1) begin sx = h / 2; sy = v / 2; end
         else if (mode == 2) begin sx = (3 * h) / 8; sy = (3 * v) / 8; end
         else begin sx = h; sy = v; end
         rec_rst[s]  = !rst_in;
         rec_ir[s]   = (sx < 240) && (sy < 320);
         rec_addr[s] = rec_ir[s] ? sy * 240 + sx : 0;
         rec_hs[s]   = hsync_in;
         rec_vs[s]   = vsync_in;
         rec_bl[s]   = blank_in;
      end
   end

   // Compare every cycle: outputs after edge s reflect sample s-L+1 unless a reset lies in between.
   initial begin
      int  p, e_pix;
      bit  valid, e_hs, e_vs, e_bl, e_ir;
      forever begin
         @(negedge clk_in);
         if (s >= 1) begin
            p = s - L + 1;
            valid = (p >= 1);
            for (int k = p; k <= s; k++) if (k >= 1 && rec_rst[k]) valid = 0;
            if (valid) begin
               e_hs  = rec_hs[p];
               e_vs  = rec_vs[p];
               e_bl  = rec_bl[p];
               e_ir  = rec_ir[p] && !rec_bl[p];
               e_pix = rec_bl[p] ? 0 : (!rec_ir[p] ? 0 : (rec_addr[p] & 16'hFFFF));
            end else begin
               e_hs = 0; e_vs = 0; e_bl = 1; e_ir = 0; e_pix = 0;
            end
            chk($sformatf("model.addr@%0d", s), 32'(addr_out), rec_rst[s] ? 0 : rec_addr[s]);
            chk($sformatf("model.pixel@%0d", s), 32'(pixel_out), e_pix);
            chk($sformatf("model.hsync@%0d", s), 32'(hsync_out), int'(e_hs));
            chk($sformatf("model.vsync@%0d", s), 32'(vsync_out), int'(e_vs));
            chk($sformatf("model.blank@%0d", s), 32'(blank_out), int'(e_bl));
            chk($sformatf("model.in_region@%0d", s), 32'(in_region_out), int'(e_ir));
         end
      end
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // Hold one coordinate for L samples; addr checked after 1 edge, pixel after L edges.
   task automatic vec(input string name, input bit nf, input logic [1:0] sc, input int h, input int v,
                      input int e_addr, input int e_pix, input bit e_ir);
      new_frame_in = nf;
      scale_in     = sc;
      hcount_in    = 11'(h);
      vcount_in    = 10'(v);
      step();
      new_frame_in = 1'b0;
      chk({name, ".addr"}, 32'(addr_out), e_addr);
      repeat (L - 1) step();
      chk({name, ".pixel"}, 32'(pixel_out), e_pix);
      chk({name, ".in_region"}, 32'(in_region_out), int'(e_ir));
      $display("vec %-10s h=%0d v=%0d scale=%0d nf=%0d -> addr=%0d pixel=%h in_region=%0d",
               name, h, v, sc, nf, e_addr, e_pix, e_ir);
   endtask

   initial begin
      rst_in = 1'b0; scale_in = 2'd0; new_frame_in = 1'b0;
      hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; vsync_in = 1'b0; blank_in = 1'b0;
      repeat (3) step();
      chk("reset.addr", 32'(addr_out), 0);
      chk("reset.pixel", 32'(pixel_out), 0);
      chk("reset.blank", 32'(blank_out), 1);
      chk("reset.in_region", 32'(in_region_out), 0);
      rst_in = 1'b1;

      vec("m0_h239", 0, 2'd0, 239, 120, 29039, 16'h716F, 1);
      vec("m0_h240", 0, 2'd0, 240, 120, 0, 16'h0000, 0);
      vec("m1_h479", 1, 2'd1, 479, 120, 14639, 16'h392F, 1);
      vec("m1_h480", 0, 2'd1, 480, 120, 0, 16'h0000, 0);
      vec("m2_v852", 1, 2'd2, 639, 852, 76799, 16'h2BFF, 1);
      vec("m2_v853", 0, 2'd2, 639, 853, 76799, 16'h2BFF, 1);
      vec("m2_v854", 0, 2'd2, 639, 854, 0, 16'h0000, 0);
      vec("m2_h640", 0, 2'd2, 640, 10, 0, 16'h0000, 0);
      vec("res3", 1, 2'd3, 239, 120, 29039, 16'h716F, 1);
      vec("m0_h300", 1, 2'd0, 300, 10, 0, 16'h0000, 0);
      vec("latch_hold", 0, 2'd1, 300, 10, 0, 16'h0000, 0);
      vec("latch_new", 1, 2'd1, 300, 10, 1350, 16'h0546, 1);

      // Blank/sync edge must emerge exactly L cycles later.
      vec("pre_blank", 1, 2'd0, 5, 1, 245, 16'h00F5, 1);
      blank_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
      for (int k = 1; k <= L; k++) begin
         step();
         if (k < L) begin
            chk($sformatf("align.blank_k%0d", k), 32'(blank_out), 0);
            chk($sformatf("align.hsync_k%0d", k), 32'(hsync_out), 0);
            chk($sformatf("align.pixel_k%0d", k), 32'(pixel_out), 16'h00F5);
         end else begin
            chk("align.blank_L", 32'(blank_out), 1);
            chk("align.hsync_L", 32'(hsync_out), 1);
            chk("align.vsync_L", 32'(vsync_out), 1);
            chk("align.pixel_L", 32'(pixel_out), 0);
            chk("align.in_region_L", 32'(in_region_out), 0);
         end
      end
      $display("blank/hsync/vsync raised, seen on outputs after %0d cycles", L);
      blank_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
      repeat (L) step();

      // Mid-stream reset with a simultaneous new_frame: reset wins, mode returns to 1x.
      vec("m2_full", 1, 2'd2, 100, 100, 8917, 16'h22D5, 1);
      rst_in = 1'b0; new_frame_in = 1'b1; scale_in = 2'd2;
      step();
      chk("rst.addr", 32'(addr_out), 0);
      chk("rst.pixel", 32'(pixel_out), 0);
      chk("rst.hsync", 32'(hsync_out), 0);
      chk("rst.vsync", 32'(vsync_out), 0);
      chk("rst.blank", 32'(blank_out), 1);
      chk("rst.in_region", 32'(in_region_out), 0);
      rst_in = 1'b1; new_frame_in = 1'b0;
      for (int k = 1; k <= L; k++) begin
         step();
         if (k == 1) chk("post_rst.addr", 32'(addr_out), 24100);
         if (k < L) chk($sformatf("post_rst.pixel_k%0d", k), 32'(pixel_out), 0);
         else chk("post_rst.pixel_L", 32'(pixel_out), 16'h5E24);
      end
      $display("reset mid-stream: 1x mapping addr=24100 pixel=5e24 after release");
      repeat (2) step();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/frame_scaler_pipe.md
Name: frame_scaler_pipe

Overview:
- Pipelined successor to the combinational camera-frame scaler.
- Maps the video generator's hcount/vcount onto a SRC_W x SRC_H camera frame buffer at one of three zoom modes.
- Issues the buffer read address and returns the fetched pixel, with all video sideband delayed to match.
- Sits between the video signal generator / frame buffer BRAM and the display compositing stage.

Parameters:
- SRC_W, 240: source frame width in pixels.
- SRC_H, 320: source frame height in pixels.
- PIXEL_W, 16: pixel width (RGB565 by default).
- READ_LATENCY, 2: frame buffer read latency in cycles, from addr_out to frame_buff_in valid.
- BORDER_COLOR, 16'h0000: pixel value driven outside the scaled region.
- ADDR_W, $clog2(SRC_W*SRC_H): address width, 17 at the defaults.

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  synchronous reset, active-low
- scale_in  input  2  requested mode: 0 = 1x, 1 = 2x, 2 = 8/3x, 3 = reserved (behaves as 0)
- new_frame_in  input  1  single-cycle frame-start pulse; the mode is latched here
- hcount_in  input  11  horizontal pixel count
- vcount_in  input  10  vertical pixel count
- hsync_in  input  1  horizontal sync
- vsync_in  input  1  vertical sync
- blank_in  input  1  blanking interval flag
- frame_buff_in  input  PIXEL_W  frame buffer read data
- addr_out  output  ADDR_W  frame buffer read address
- pixel_out  output  PIXEL_W  scaled pixel
- hsync_out  output  1  hsync_in delayed by L
- vsync_out  output  1  vsync_in delayed by L
- blank_out  output  1  blank_in delayed by L
- in_region_out  output  1  high when pixel_out is taken from the frame buffer

Behaviour:
- Latency L = READ_LATENCY + 2 from an input sample to pixel_out and the sideband outputs.
- addr_out is registered, 1 cycle after the input sample.
- frame_buff_in is consumed READ_LATENCY cycles after addr_out; pixel_out is registered one cycle after that.
- Mode register mode_q:
  - Reset value 0.
  - Loads scale_in (3 maps to 0) on any cycle with new_frame_in=1.
  - Otherwise holds, so scale_in changes mid-frame have no effect until the next frame.
  - The coordinate computation on the new_frame_in cycle already uses the newly loaded mode, i.e. mode_next.
- Source coordinates from (h, v) = (hcount_in, vcount_in):
  - Mode 0: sx = h, sy = v.
  - Mode 1: sx = h>>1, sy = v>>1.
  - Mode 2: sx = (3h)>>3, sy = (3v)>>3; the products are computed at 13 bits with no truncation before the shift.
- in_region = (sx < SRC_W) && (sy < SRC_H). With the defaults the region ends at:
  - h = 239 / 479 / 639 inclusive for modes 0 / 1 / 2;
  - v = 319 / 639 / 853 inclusive for modes 0 / 1 / 2.
- addr_out = sy*SRC_W + sx when in_region, else 0.
- pixel_out selection, in priority order:
  - delayed blank = 1 → 0;
  - else delayed in_region = 0 → BORDER_COLOR;
  - else frame_buff_in.
- in_region_out is delayed in_region AND NOT delayed blank.
- hsync, vsync, blank and in_region travel in shift registers of matching depth. There are no bubbles and no stalls; the block accepts one sample per cycle.
- Reset (rst_in=0 at a clock edge):
  - mode_q = 0;
  - all pipeline stages cleared;
  - addr_out = 0, pixel_out = 0, hsync_out = 0, vsync_out = 0, blank_out = 1, in_region_out = 0;
  - the first valid outputs after release appear L cycles after the first sampled input.
- Reset applied mid-frame discards in-flight samples; nothing stale emerges after release.
- Simultaneous new_frame_in and reset: reset wins and mode_q = 0.
- No wrap-around handling: hcount/vcount come from the generator. Values beyond the source extent map to the border, never to an aliased address.

Test Plan:
- Mode 0, READ_LATENCY=2, v=120, h=239 then 240, BRAM model returning addr[15:0]:
  - h=239 → addr_out = 29039 one cycle later; pixel_out = 16'h716F at L=4; in_region_out = 1.
  - h=240 → addr_out = 0; pixel_out = BORDER_COLOR; in_region_out = 0.
- Mode 1 (latched by a new_frame_in pulse), v=120:
  - h=479 → addr_out = 60*240+239 = 14639.
  - h=480 → border, in_region_out = 0.
- Mode 2, h=639:
  - v=852 → sy=319, addr_out = 76799.
  - v=853 → addr_out = 76799.
  - v=854 → border.
  - Also h=640, v=10 → border.
- Mode latch: mode 0 active, drive scale_in=1 mid-frame with h=300, v=10:
  - Output stays border until new_frame_in pulses.
  - After the pulse the same coordinates give addr_out = 5*240+150 = 1350.
- Blank and sync alignment: toggle blank_in/hsync_in on a known cycle.
  - blank_out, hsync_out and pixel_out = 0 change exactly L cycles later.
  - in_region_out = 0 during blank.
- Reset mid-stream: mode 2 active with the pipeline full, drive rst_in=0 for one cycle.
  - Next edge: outputs take their reset values; mode_q = 0.
  - After release, mode 0 mapping applies until the next new_frame_in.
  - No pre-reset pixel ever appears on pixel_out.
